dram_rd_ctrl: RTL and testbench

- Upstream request controller for the 8-lane DRAM model.
- Turns one byte-range read request (base address, length) from the protobuf parser front end into batches of up to 8 single-byte DRAM lane reads.
- Captures each batch's returned bytes and streams them out one byte per cycle with ready/valid backpressure.
- Sole master of the DRAM request port; the parser's input byte stream is its consumer.

---
 rtl/dram_rd_ctrl.sv | 153 +++++++++++++++
 tb/tb_dram_rd_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_rd_ctrl.sv
// Read-request controller: splits a byte-range read into batches of up to 8 DRAM lane reads
// and streams the returned bytes with ready/valid. Optional DRAM_RD_TIMEOUT_EN adds a WAIT timeout and sticky err.
module dram_rd_ctrl #(
  parameter int DRAM_LAT   = 22,
  parameter int LEN_W      = 16,
  parameter int TMO_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [63:0]          req_addr,
  input  logic [LEN_W-1:0]     req_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic [7:0]           mem_en,
  output logic                 mem_rdwr,
  output logic [7:0][63:0]     mem_addr,
  output logic [7:0][7:0]      mem_data_in,
  input  logic [7:0][7:0]      mem_data_out,
  input  logic [7:0]           mem_valid
`ifdef DRAM_RD_TIMEOUT_EN
  ,output logic                err
`endif
);

  localparam int CNT_MAX = (TMO_CYCLES > DRAM_LAT) ? TMO_CYCLES : DRAM_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [63:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [3:0]         n_q, n_d;
  logic [2:0]         k_q, k_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0][7:0]    buf_q, buf_d;
  logic [7:0][63:0]   maddr_q, maddr_d;
  logic [7:0]         lane_mask;
  logic               cap, tmo, last_lane;

  always_comb begin
    for (int i = 0; i < 8; i++) lane_mask[i] = (4'(i) < n_q);
  end

  // mem_valid is sticky from the previous batch, so it only counts once DRAM_LAT has elapsed
  assign cap = (state_q == WAIT) && (cnt_q >= CNT_W'(DRAM_LAT)) &&
               ((mem_valid & lane_mask) == lane_mask);
`ifdef DRAM_RD_TIMEOUT_EN
  logic err_q, err_d;
  assign tmo = (state_q == WAIT) && !cap && (cnt_q >= CNT_W'(TMO_CYCLES));
  assign err = err_q;
`else
  assign tmo = 1'b0;
`endif

  assign last_lane   = (4'(k_q) + 4'd1 == n_q);
  assign req_ready   = reset && (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign mem_en      = (state_q == WAIT && !cap && !tmo) ? lane_mask : 8'h00;
  assign mem_rdwr    = reset;
  assign mem_addr    = maddr_q;
  assign mem_data_in = '0;
  assign out_valid   = (state_q == DRAIN);
  assign out_data    = out_valid ? buf_q[k_q] : 8'h00;
  assign out_last    = out_valid && last_lane && (rem_q == LEN_W'(n_q));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    n_d     = n_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    maddr_d = maddr_q;
`ifdef DRAM_RD_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (req_valid && req_ready) begin
        addr_d = req_addr;
        rem_d  = req_len;
        if (req_len != '0) state_d = ISSUE;
      end
      ISSUE: begin
        n_d = (rem_q > LEN_W'(8)) ? 4'd8 : rem_q[3:0];
        for (int i = 0; i < 8; i++)
          maddr_d[i] = (4'(i) < n_d) ? addr_q + 64'(i) : 64'd0;
        cnt_d   = '0;
        k_d     = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (cap) begin
          for (int i = 0; i < 8; i++)
            buf_d[i] = lane_mask[i] ? mem_data_out[i] : 8'h00;
          state_d = DRAIN;
        end else if (tmo) begin
`ifdef DRAM_RD_TIMEOUT_EN
          err_d = 1'b1;
`endif
          state_d = IDLE;
        end
      end
      DRAIN: if (out_ready) begin
        if (last_lane) begin
          rem_d   = rem_q - LEN_W'(n_q);
          addr_d  = addr_q + 64'(n_q);
          k_d     = '0;
          state_d = (rem_q == LEN_W'(n_q)) ? IDLE : ISSUE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      n_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      maddr_q <= '0;
`ifdef DRAM_RD_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      n_q     <= n_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      maddr_q <= maddr_d;
`ifdef DRAM_RD_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_dram_rd_ctrl.sv
// Directed bench for dram_rd_ctrl with a sticky-valid 8-lane DRAM model; byte at address a is a[7:0]^8'h5A.
module tb_dram_rd_ctrl;
  localparam int LAT = 22;
  localparam int TMO = 255;

  typedef logic [7:0][63:0] addr8_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [63:0]      req_addr;
  logic [15:0]      req_len;
  logic             out_valid, out_ready, out_last, busy, mem_rdwr;
  logic [7:0]       out_data, mem_en, mem_valid;
  logic [7:0][63:0] mem_addr;
  logic [7:0][7:0]  mem_data_in, mem_data_out;
`ifdef DRAM_RD_TIMEOUT_EN
  logic             err;
`endif

  dram_rd_ctrl #(.DRAM_LAT(LAT), .LEN_W(16), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .mem_en(mem_en),
    .mem_rdwr(mem_rdwr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_valid(mem_valid)
`ifdef DRAM_RD_TIMEOUT_EN
    ,.err(err)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // DRAM model: valid rises after 4 enabled cycles and lingers 12 cycles after enable drops
  logic [7:0]      vld = '0;
  logic [7:0][7:0] dat = '0;
  int              hi_cnt [8];
  int              lo_cnt [8];
  bit              force0 = 1'b0;
  initial for (int i = 0; i < 8; i++) begin hi_cnt[i] = 0; lo_cnt[i] = 0; end
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (mem_en[i]) begin
        hi_cnt[i] <= hi_cnt[i] + 1;
        lo_cnt[i] <= 0;
        if (hi_cnt[i] == 3) begin
          vld[i] <= 1'b1;
          dat[i] <= mem_addr[i][7:0] ^ 8'h5A;
        end
      end else begin
        hi_cnt[i] <= 0;
        lo_cnt[i] <= lo_cnt[i] + 1;
        if (lo_cnt[i] >= 12) vld[i] <= 1'b0;
      end
    end
  end
  assign mem_valid    = force0 ? 8'h00 : vld;
  assign mem_data_out = dat;

  // out_ready pattern 1-0-0-1-0-0 when tog is set
  bit tog = 1'b0;
  always @(posedge clk) begin
    #1 out_ready = tog ? (cyc % 3 == 0) : 1'b1;
  end

  // Monitor, sampled on the falling edge
  logic [7:0] bytes[$];
  logic       lasts[$];
  logic [7:0] rise_en[$];
  addr8_t     rise_addr[$];
  int         rise_t[$];
  int         min_gap, low_run, hold_err, en_drain, addr_unst, t_acc, t_first;
  bit         vseen, busy_seen, stall_prev, pl;
  logic [7:0] pd, prev_en;
  addr8_t     prev_addr;

  task automatic clear_mon();
    bytes.delete(); lasts.delete(); rise_en.delete(); rise_addr.delete(); rise_t.delete();
    min_gap = 1000; low_run = 1000; hold_err = 0; en_drain = 0; addr_unst = 0;
    t_acc = 0; t_first = 0; vseen = 0; busy_seen = 0; stall_prev = 0;
  endtask

  always @(negedge clk) begin
    if (req_valid && req_ready) t_acc = cyc;
    if (mem_en != 0 && prev_en == 0) begin
      rise_en.push_back(mem_en); rise_addr.push_back(mem_addr); rise_t.push_back(cyc);
      if (low_run < min_gap) min_gap = low_run;
    end
    if (mem_en != 0 && prev_en != 0 && mem_addr != prev_addr) addr_unst++;
    low_run = (mem_en == 0) ? low_run + 1 : 0;
    if (out_valid && !vseen) begin vseen = 1; t_first = cyc; end
    if (out_valid && mem_en != 0) en_drain++;
    if (stall_prev && (!out_valid || out_data != pd || out_last != pl)) hold_err++;
    stall_prev = out_valid && !out_ready; pd = out_data; pl = out_last;
    if (out_valid && out_ready) begin bytes.push_back(out_data); lasts.push_back(out_last); end
    if (busy) busy_seen = 1;
    prev_en = mem_en; prev_addr = mem_addr;
  end

  task automatic send(input logic [63:0] a, input logic [15:0] l);
    int i;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_len = l;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    chk("req_accept", (i < 20), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n);
    for (int i = 0; i < 3000 && bytes.size() < n; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk(tag, bytes.size(), n);
  endtask

  task automatic chk_stream(input string tag, input logic [63:0] a, input int n);
    int nl;
    nl = 0;
    for (int i = 0; i < n && i < bytes.size(); i++) begin
      chk({tag, "_byte"}, bytes[i], 8'(a + 64'(i)) ^ 8'h5A);
      if (lasts[i]) nl++;
    end
    chk({tag, "_nlast"}, nl, 1);
    if (bytes.size() >= n) chk({tag, "_last_pos"}, lasts[n-1], 1);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_out_valid", out_valid, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", req_ready, 1);
    chk("rdwr", mem_rdwr, 1);

    // single 5-byte batch
    clear_mon();
    send(64'h10, 16'd5);
    wait_bytes("t1_count", 5);
    chk("t1_batches", rise_en.size(), 1);
    if (rise_en.size() >= 1) begin
      chk("t1_en", rise_en[0], 8'h1F);
      chk("t1_lane0", rise_addr[0][0], 64'h10);
      chk("t1_lane4", rise_addr[0][4], 64'h14);
      chk("t1_lane5", rise_addr[0][5], 64'h0);
    end
    chk("t1_lat_min", (t_first - t_acc) >= LAT + 2, 1);
    chk_stream("t1", 64'h10, 5);
    chk("t1_idle", busy, 0);

    // 19 bytes: three batches, stale valid between batches
    clear_mon();
    send(64'h0, 16'd19);
    wait_bytes("t2_count", 19);
    chk("t2_batches", rise_en.size(), 3);
    if (rise_en.size() == 3) begin
      chk("t2_en0", rise_en[0], 8'hFF);
      chk("t2_en1", rise_en[1], 8'hFF);
      chk("t2_en2", rise_en[2], 8'h07);
      chk("t2_b2_lane0", rise_addr[2][0], 64'd16);
      chk("t2_b2_lane3", rise_addr[2][3], 64'd0);
      chk("t2_period", rise_t[1] - rise_t[0], 8 + LAT + 2);
    end
    chk("t2_gap", min_gap >= 2, 1);
    chk("t2_addr_stable", addr_unst, 0);
    chk_stream("t2", 64'h0, 19);

    // backpressure
    clear_mon();
    tog = 1'b1;
    send(64'h200, 16'd8);
    wait_bytes("t3_count", 8);
    tog = 1'b0;
    chk("t3_hold", hold_err, 0);
    chk("t3_en_drain", en_drain, 0);
    chk_stream("t3", 64'h200, 8);

    // zero-length request
    clear_mon();
    send(64'h300, 16'd0);
    repeat (40) @(negedge clk);
    chk("t4_no_en", rise_en.size(), 0);
    chk("t4_no_valid", vseen, 0);
    chk("t4_no_busy", busy_seen, 0);
    chk("t4_ready", req_ready, 1);

    // asynchronous reset during WAIT
    clear_mon();
    send(64'h100, 16'd16);
    for (int i = 0; i < 50 && mem_en == 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("t5_in_wait", mem_en, 8'hFF);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_en", mem_en, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_addr", mem_addr[0], 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("t5_rel_ready", req_ready, 1);
    repeat (60) @(negedge clk);
    chk("t5_no_stale", bytes.size(), 0);
    // fresh 3-byte request that wraps past all-ones
    clear_mon();
    send(64'hFFFF_FFFF_FFFF_FFFE, 16'd3);
    wait_bytes("t6_count", 3);
    chk("t6_batches", rise_en.size(), 1);
    if (rise_en.size() >= 1) begin
      chk("t6_en", rise_en[0], 8'h07);
      chk("t6_lane1", rise_addr[0][1], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t6_lane2", rise_addr[0][2], 64'h0);
    end
    chk_stream("t6", 64'hFFFF_FFFF_FFFF_FFFE, 3);

`ifdef DRAM_RD_TIMEOUT_EN
    begin
      int t_err;
      clear_mon();
      chk("t7_err0", err, 0);
      force0 = 1'b1;
      send(64'h40, 16'd4);
      t_err = -1;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (err) begin t_err = cyc; break; end
      end
      chk("t7_err", err, 1);
      if (rise_t.size() > 0) chk("t7_tmo_cycles", t_err - rise_t[0], TMO + 1);
      chk("t7_en", mem_en, 0);
      chk("t7_ready", req_ready, 1);
      chk("t7_no_bytes", bytes.size(), 0);
      force0 = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
